fifo_txuart: RTL and testbench



---
 rtl/fifo_txuart.sv | 124 ++++++++++++
 tb/tb_fifo_txuart.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_txuart.sv
// rtl/fifo_txuart.sv - FIFO-draining 8N1 UART transmitter
//
// Reads bytes from a synchronous FIFO's read port and serialises each one as
// an 8N1 frame (start, 8 data bits LSB first, stop). Frames go out back to
// back with no idle gap while the FIFO stays non-empty.
//
// Ports:
//   i_clk         system clock, all logic on posedge
//   i_reset       synchronous active-high reset
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO head word, valid whenever i_fifo_empty is low
//   o_fifo_rd     combinational read strobe; FIFO advances on the edge it is high
//   o_uart_tx     registered serial line, idles high
//   o_busy        registered, high while a frame is in progress
module fifo_txuart #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned LGBAUD          = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_rd,
    output logic       o_uart_tx,
    output logic       o_busy
);

    // Reject a divider that is too small or that the counter cannot hold.
    generate
        if (CLOCKS_PER_BAUD < 2 || (LGBAUD < 32 && (CLOCKS_PER_BAUD >> LGBAUD) != 0)) begin : g_bad_cfg
            $error("fifo_txuart: CLOCKS_PER_BAUD does not fit in LGBAUD bits or is below 2");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_D0    = 4'd2,
        S_D1    = 4'd3,
        S_D2    = 4'd4,
        S_D3    = 4'd5,
        S_D4    = 4'd6,
        S_D5    = 4'd7,
        S_D6    = 4'd8,
        S_D7    = 4'd9,
        S_STOP  = 4'd10
    } state_t;

    localparam logic [LGBAUD-1:0] RELOAD = LGBAUD'(CLOCKS_PER_BAUD - 1);
    localparam logic [LGBAUD-1:0] ONE    = LGBAUD'(1);

    state_t            state_q, state_d;
    logic [LGBAUD-1:0] cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              cnt_zero;
    logic [3:0]        next_bit;

    assign cnt_zero = (cnt_q == '0);
    // Bit to drive when leaving START/D0..D6: START -> bit 0, Dk -> bit k+1.
    assign next_bit = state_q - 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        o_fifo_rd = !i_reset && !i_fifo_empty &&
                    (state_q == S_IDLE || (state_q == S_STOP && cnt_zero));

        if (o_fifo_rd) begin
            // Byte is consumed at frame start; start bit appears next cycle.
            state_d = S_START;
            cnt_d   = RELOAD;
            shift_d = i_fifo_data;
            tx_d    = 1'b0;
        end else if (state_q != S_IDLE) begin
            if (!cnt_zero) begin
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = RELOAD;
                case (state_q)
                    S_STOP: begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        tx_d    = 1'b1;
                    end
                    S_D7: begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                    default: begin
                        state_d = state_t'(state_q + 4'd1);
                        tx_d    = shift_q[next_bit[2:0]];
                    end
                endcase
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_fifo_txuart.sv
// tb/tb_fifo_txuart.sv - self-checking bench for fifo_txuart
module tb_fifo_txuart;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       o_fifo_rd;
    logic       o_uart_tx;
    logic       o_busy;

    fifo_txuart #(.CLOCKS_PER_BAUD(N), .LGBAUD(24)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_fifo_empty(fifo_empty),
        .i_fifo_data (fifo_data),
        .o_fifo_rd   (o_fifo_rd),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = -1;
    always @(posedge clk) cyc++;

    int n_tot  = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endfunction

    // FIFO contents as seen by the DUT
    logic [7:0] q[$];
    logic       rd_seen = 1'b0;

    // Behavioural model: a frame started by a read in cycle t0 owns cycles t0+1..t0+10N
    bit         chk_en = 1'b0;
    bit         m_act  = 1'b0;
    int         m_t0;
    logic [7:0] m_byte;
    int         busy_cnt;
    int         rd_cycles[$];

    // Independent line decoder
    bit         d_act = 1'b0;
    int         d_cnt;
    logic [7:0] d_sh;
    logic [7:0] dec_q[$];

    always @(negedge clk) begin
        int   k;
        int   b;
        int   j;
        logic exp_tx;
        logic exp_rd;
        rd_seen = o_fifo_rd;
        if (chk_en) begin
            k = cyc - m_t0;
            exp_rd = !rst && !fifo_empty && (!m_act || k == 10 * N);
            if (m_act) begin
                b = (k - 1) / N;
                if (b == 0)      exp_tx = 1'b0;
                else if (b == 9) exp_tx = 1'b1;
                else             exp_tx = m_byte[b-1];
            end else begin
                exp_tx = 1'b1;
            end
            chk("uart_tx", {31'd0, o_uart_tx}, {31'd0, exp_tx});
            chk("busy", {31'd0, o_busy}, {31'd0, m_act});
            chk("fifo_rd", {31'd0, o_fifo_rd}, {31'd0, exp_rd});
            if (o_fifo_rd) rd_cycles.push_back(cyc);
            if (o_busy) busy_cnt++;

            if (rst) m_act = 1'b0;
            else if (exp_rd) begin
                m_act  = 1'b1;
                m_t0   = cyc;
                m_byte = fifo_data;
            end else if (m_act && k == 10 * N) m_act = 1'b0;

            if (rst) d_act = 1'b0;
            else begin
                if (!d_act && o_uart_tx == 1'b0) begin
                    d_act = 1'b1;
                    d_cnt = 0;
                end
                if (d_act) begin
                    d_cnt++;
                    if (d_cnt % N == N / 2) begin
                        j = d_cnt / N;
                        if (j >= 1 && j <= 8) d_sh[j-1] = o_uart_tx;
                        if (j == 9) begin
                            if (o_uart_tx) dec_q.push_back(d_sh);
                            d_act = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic upd();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? 8'($urandom) : q[0];
    endtask

    task automatic push(logic [7:0] v);
        q.push_back(v);
        upd();
    endtask

    task automatic step();
        logic [7:0] tmp;
        @(posedge clk);
        #1;
        if (rd_seen) tmp = q.pop_front();
        upd();
    endtask

    task automatic wait_idle(int lim);
        int n = 0;
        while ((m_act || q.size() != 0) && n < lim) begin
            step();
            n++;
        end
        chk("idle_reached", {31'd0, (m_act || q.size() != 0)}, 32'd0);
        step();
        step();
    endtask

    task automatic chk_dec(string nm, logic [7:0] exp[$]);
        chk({nm, "_count"}, dec_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dec_q.size(); i++)
            chk({nm, "_byte"}, {24'd0, dec_q[i]}, {24'd0, exp[i]});
    endtask

    task automatic clear_logs();
        dec_q.delete();
        rd_cycles.delete();
        busy_cnt = 0;
    endtask

    initial begin
        logic [7:0] rnd[$];
        int idx;
        int t0;
        int lim;

        // Reset held 3 cycles with 0xA5 at the head
        rst = 1'b1;
        push(8'hA5);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_low", {31'd0, o_fifo_rd}, 32'd0);
            chk("rst_tx_high", {31'd0, o_uart_tx}, 32'd1);
            chk("rst_busy_low", {31'd0, o_busy}, 32'd0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_rd_after_rst", {31'd0, o_fifo_rd}, 32'd1);
        step();
        @(negedge clk);
        chk("first_start_bit", {31'd0, o_uart_tx}, 32'd0);
        wait_idle(200);
        chk_dec("a5", '{8'hA5});

        // Single byte 0x55
        clear_logs();
        push(8'h55);
        wait_idle(200);
        chk("single_rd_pulses", rd_cycles.size(), 1);
        chk("single_busy_cycles", busy_cnt, 40);
        chk_dec("x55", '{8'h55});

        // Three bytes back to back
        clear_logs();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle(400);
        chk("b2b_rd_pulses", rd_cycles.size(), 3);
        if (rd_cycles.size() == 3) begin
            chk("b2b_gap1", rd_cycles[1] - rd_cycles[0], 40);
            chk("b2b_gap2", rd_cycles[2] - rd_cycles[1], 40);
        end
        chk("b2b_busy_cycles", busy_cnt, 120);
        chk_dec("b2b", '{8'h00, 8'hFF, 8'h3C});

        // Reset in cycle 18 of a frame carrying 0x81, 0x7E queued behind it
        clear_logs();
        push(8'h81);
        push(8'h7E);
        lim = 0;
        while (!m_act && lim < 10) begin step(); lim++; end
        t0 = m_t0;
        lim = 0;
        while (cyc < t0 + 18 && lim < 40) begin step(); lim++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx_high", {31'd0, o_uart_tx}, 32'd1);
        chk("midrst_rd_7e", {31'd0, o_fifo_rd}, 32'd1);
        wait_idle(200);
        chk("midrst_rd_pulses", rd_cycles.size(), 2);
        chk_dec("midrst", '{8'h7E});

        // 0x12 arrives during the STOP bit of a 0x11 frame
        clear_logs();
        push(8'h11);
        lim = 0;
        while (!m_act && lim < 10) begin step(); lim++; end
        t0 = m_t0;
        lim = 0;
        while (cyc < t0 + 9 * N + 2 && lim < 60) begin step(); lim++; end
        push(8'h12);
        wait_idle(200);
        chk("stop_rd_pulses", rd_cycles.size(), 2);
        if (rd_cycles.size() == 2) chk("stop_rd_gap", rd_cycles[1] - rd_cycles[0], 40);
        chk_dec("stop", '{8'h11, 8'h12});

        // Random 64-byte stream with random arrival times
        clear_logs();
        for (int i = 0; i < 64; i++) rnd.push_back(8'($urandom));
        idx = 0;
        lim = 0;
        while (idx < 64 && lim < 20000) begin
            if ($urandom_range(0, 99) < 4) begin
                push(rnd[idx]);
                idx++;
                if (idx < 64 && $urandom_range(0, 1) == 1) begin
                    push(rnd[idx]);
                    idx++;
                end
            end
            step();
            lim++;
        end
        wait_idle(5000);
        chk("rand_fifo_empty", q.size(), 0);
        chk("rand_rd_pulses", rd_cycles.size(), 64);
        chk_dec("rand", rnd);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
